// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, sign fix-up at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] wlo;

    logic             s_a;
    logic             s_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    assign s_a   = ~op[0] & A[WIDTH-1];
    assign s_b   = ~op[0] & B[WIDTH-1];
    assign a_mag = s_a ? -A : A;
    assign b_mag = s_b ? -B : B;

    assign add     = {1'b0, acc} + (wlo[0] ? {1'b0, opnd} : '0);
    assign shifted = {acc, wlo[WIDTH-1]};
    assign trial   = shifted - {1'b0, opnd};

    // Magnitudes are unsigned; the final sign is restored in FIX.
    assign prod = neg_q ? -{acc, wlo} : {acc, wlo};
    assign quot = neg_q ? -wlo : wlo;
    assign rem  = neg_r ? -acc : acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            wlo    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= s_a ^ s_b;
                        neg_r  <= s_a;
                        opnd   <= op[1] ? b_mag : a_mag;
                        wlo    <= op[1] ? a_mag : b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                        dz     <= op[1] && (B == '0);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= trial[WIDTH] ? shifted[WIDTH-1:0]
                                            : trial[WIDTH-1:0];
                        wlo <= {wlo[WIDTH-2:0], ~trial[WIDTH]};
                    end else begin
                        acc <= add[WIDTH:1];
                        wlo <= {add[0], wlo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    // Divide by zero leaves rem == A after sign fix-up.
                    if (is_div) begin
                        hi <= rem;
                        lo <= dz ? '1 : quot;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops, latency, HI/LO writes, reset abort.
// Expected results are pushed at launch and popped by a monitor on each done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_run = 0;
    int   vectors = 0;
    int   miscompares = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h",
                             cyc, hi, lo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (hi !== e.hi || lo !== e.lo || dz !== e.dz ||
                        cyc != e.cyc || busy_run != 33) begin
                        miscompares++;
                        $display("FAIL result got hi=%h lo=%h dz=%b cyc=%0d busy=%0d want hi=%h lo=%h dz=%b cyc=%0d busy=33",
                                 hi, lo, dz, cyc, busy_run,
                                 e.hi, e.lo, e.dz, e.cyc);
                    end
                end
                busy_run = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic push,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ed);
        exp_t e;
        op = o;
        A = a;
        B = b;
        start = 1'b1;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.dz = ed;
            e.cyc = cyc + 34;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout got done=0 want done=1");
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh,
                       input logic [31:0] el, input logic ed);
        launch(o, a, b, 1'b1, eh, el, ed);
        drain();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op = 2'b00;
        A = '0;
        B = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dz", {31'b0, dz}, 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        run(MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run(DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run(DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0);

        launch(DIVU, 32'd7, 32'd0, 1'b1, 32'h7, 32'hFFFFFFFF, 1'b1);
        wait_done();
        launch(DIVU, 32'd7, 32'd2, 1'b1, 32'h1, 32'h3, 1'b0);
        drain();

        run(DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        run(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run(MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0);

        launch(MULTU, 32'd3, 32'd4, 1'b1, 32'h0, 32'hC, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        op = DIVU;
        A = 32'd9;
        B = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain();

        hi_we = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1 hi_we = 1'b0;
        chk("mthi_idle", hi, 32'hA5A5A5A5);
        chk("mthi_lo_kept", lo, 32'hC);

        hi_we = 1'b1;
        wdata = 32'h12345678;
        launch(MULTU, 32'd2, 32'd3, 1'b1, 32'h0, 32'h6, 1'b0);
        hi_we = 1'b0;
        chk("start_beats_mthi", hi, 32'hA5A5A5A5);
        repeat (4) @(posedge clk);
        #1;
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 hi_we = 1'b0;
        chk("mthi_busy", hi, 32'hA5A5A5A5);
        wait_done();
        lo_we = 1'b1;
        wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 lo_we = 1'b0;
        chk("mtlo_done_override", lo, 32'hCAFEF00D);
        chk("hi_after_override", hi, 32'h0);

        launch(MULTU, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        repeat (40) @(negedge clk);
        chk("abort_lo_later", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
